fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one FIFO write port (data_in/wr_en) among NUM_REQ producers. It uses valid/ready handshakes on the producer side and throttles on the FIFO's full/almostfull flags so the FIFO never overflows. It checks every issued write for a wr_ack and enters a sticky ERROR state on a protocol violation. It sits between producer blocks and the FIFO's TEST-side signals.

Parameters:
FIFO_WIDTH, 16, data word width (matches FIFO).
NUM_REQ, 4, number of requesters (2..8).
CNT_WIDTH, 8, width of saturating accepted-write counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester word available.
req_data  input  NUM_REQ*FIFO_WIDTH  packed words, requester i at [i*FIFO_WIDTH +: FIFO_WIDTH].
req_ready  output  NUM_REQ  combinational one-hot grant; transfer when valid&ready at the edge.
pause  input  1  level: suppress new grants.
err_clr  input  1  one-cycle pulse: leave ERROR.
data_in  output  FIFO_WIDTH  registered write data to FIFO.
wr_en  output  1  registered write strobe to FIFO.
full  input  1  FIFO full.
almostfull  input  1  FIFO has exactly one free slot.
wr_ack  input  1  FIFO registered write acknowledge.
overflow  input  1  FIFO overflow flag.
grant_id  output  $clog2(NUM_REQ)  index of requester driving current wr_en.
state  output  2  00 RUN, 01 PAUSED, 10 ERROR.
ack_err  output  1  sticky: missing wr_ack or overflow seen.
accept_cnt  output  CNT_WIDTH  saturating count of accepted writes.

Behaviour:
- Reset (async, immediate): wr_en=0, data_in=0, grant_id=0, state=RUN, ack_err=0, accept_cnt=0, rr_last=NUM_REQ-1, pending_ack=0. req_ready=0 while rst_n=0.
- can_issue = (state==RUN) & !pause & !full & !(almostfull & wr_en). Reads are ignored; throttling is conservative.
- Arbitration (combinational): when can_issue, search req_valid starting at (rr_last+1) mod NUM_REQ. Grant the first set bit via req_ready one-hot. If can_issue=0 or there are no valid requesters, req_ready=0.
- On the edge with grant g:
  - wr_en<=1, data_in<=req_data[g], grant_id<=g, rr_last<=g.
  - accept_cnt increments, saturating at all-ones.
- With no grant: wr_en<=0; data_in and grant_id hold.
- Latency: accept to wr_en is 1 cycle. Throughput is 1 write per cycle. A lone requester is granted back-to-back every cycle.
- pending_ack<=wr_en. The FIFO asserts wr_ack in the cycle after wr_en. If pending_ack=1 and wr_ack=0, or overflow=1 in any cycle, then state<=ERROR and ack_err<=1.
- FSM:
  - RUN->PAUSED when pause=1 (no error). PAUSED->RUN when pause=0.
  - RUN/PAUSED->ERROR on error condition; this has priority over pause.
  - ERROR->RUN on err_clr=1, which also clears ack_err. Error and err_clr in the same cycle: ERROR wins.
  - In PAUSED/ERROR, no grants; an in-flight wr_en still completes and is ack-checked.
- Producers hold req_data stable while req_valid=1 and not yet granted. Dropping req_valid without a grant is legal.
- Full boundary: with the FIFO empty and no reads, exactly FIFO_DEPTH writes issue, then grants stop. Overflow must never be caused by this block.
- Round-robin fairness: with all valid, each requester is granted once every NUM_REQ grants. The pointer is not advanced on cycles with no grant.
- Reset mid-transfer: the in-flight write is aborted (wr_en drops asynchronously). The pointer returns to give requester 0 first priority.

Test Plan:
1. NUM_REQ=4, all req_valid=1, FIFO drained continuously -> req_ready 0001,0010,0100,1000,0001...; wr_en high every cycle; data_in equals the granted word one cycle later; accept_cnt=8 after 8 cycles.
2. Only req_valid[2]=1 for 5 cycles -> five consecutive grants to 2; grant_id=2; no gaps in wr_en.
3. FIFO depth 8, no reads, all valid -> exactly 8 wr_en pulses; the 8th coincides with almostfull, then req_ready=0; overflow never asserts; one read then re-enables exactly one grant.
4. pause=1 mid-stream after grant to 1 -> no req_ready next cycle; pending write acked; state=PAUSED; pause=0 -> next grant goes to requester 2.
5. Force wr_ack=0 the cycle after a wr_en -> state=ERROR, ack_err=1, req_ready=0 thereafter; err_clr pulse -> state=RUN, ack_err=0, grants resume.
6. Drop rst_n asynchronously mid-cycle during streaming -> wr_en, accept_cnt and ack_err are 0 immediately; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among producers
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            pause,
  input  logic                            err_clr,
  output logic [FIFO_WIDTH-1:0]           data_in,
  output logic                            wr_en,
  input  logic                            full,
  input  logic                            almostfull,
  input  logic                            wr_ack,
  input  logic                            overflow,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [1:0]                      state,
  output logic                            ack_err,
  output logic [CNT_WIDTH-1:0]            accept_cnt
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [1:0] RUN    = 2'b00;
  localparam logic [1:0] PAUSED = 2'b01;
  localparam logic [1:0] ERROR  = 2'b10;
  logic [IDW-1:0] rr_last, gnt_idx, idx;
  logic found, can_issue, grant, pending_ack, err_cond;
  // an in-flight write counts against the last free slot, so almostfull blocks it
  assign can_issue = rst_n & (state == RUN) & ~pause & ~full & ~(almostfull & wr_en);
  assign grant     = |req_ready;
  assign err_cond  = (pending_ack & ~wr_ack) | overflow;
  // Round-robin search starting just after the last granted requester
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(rr_last) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    req_ready = (can_issue & found) ? NUM_REQ'(1) << gnt_idx : '0;
  end
  // Registered write port, round-robin pointer and saturating accept counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      data_in     <= '0;
      grant_id    <= '0;
      rr_last     <= IDW'(NUM_REQ - 1);
      accept_cnt  <= '0;
      pending_ack <= 1'b0;
    end else begin
      wr_en       <= grant;
      pending_ack <= wr_en;
      if (grant) begin
        data_in    <= req_data[gnt_idx*FIFO_WIDTH +: FIFO_WIDTH];
        grant_id   <= gnt_idx;
        rr_last    <= gnt_idx;
        accept_cnt <= (&accept_cnt) ? accept_cnt : accept_cnt + 1'b1;
      end
    end
  end
  // Control FSM: a fresh error beats both err_clr and pause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      ack_err <= 1'b0;
    end else begin
      state   <= err_cond ? ERROR : (state == ERROR) ? (err_clr ? RUN : ERROR) : (pause ? PAUSED : RUN);
      ack_err <= err_cond | (ack_err & ~((state == ERROR) & err_clr));
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, corner sequences and randomized run against a reference model
module tb_fifo_wr_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic pause, err_clr, wr_en, full, almostfull, wr_ack, overflow, ack_err;
  logic [W-1:0] data_in;
  logic [1:0] grant_id, state;
  logic [7:0] accept_cnt;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pause(pause), .err_clr(err_clr), .data_in(data_in),
    .wr_en(wr_en), .full(full), .almostfull(almostfull), .wr_ack(wr_ack),
    .overflow(overflow), .grant_id(grant_id), .state(state), .ack_err(ack_err),
    .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  // stimulus knobs applied on the next falling edge
  logic [N-1:0] k_v;
  logic k_p, k_rd, k_ec, k_ka, k_oi;
  logic [N*W-1:0] k_d;
  // FIFO environment
  int fcnt;
  logic f_ack, f_ovf, f_ovf_seen;
  // reference model of the arbiter
  int m_state, m_cnt, m_last, m_gid;
  logic m_wr, m_err, m_pend;
  logic [W-1:0] m_data;
  int n_chk = 0;
  int n_pass = 0;
  int pulses;

  typedef struct {
    logic [3:0] v;
    logic [3:0] rdy;
    logic we;
    int gid;
    int cnt;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset;
    m_state = 0; m_cnt = 0; m_last = N - 1; m_gid = 0;
    m_wr = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_data = '0;
    fcnt = 0; f_ack = 1'b0; f_ovf = 1'b0;
  endtask

  task automatic idle_inputs;
    req_valid = '0; pause = 1'b0; err_clr = 1'b0; full = 1'b0;
    almostfull = 1'b0; wr_ack = 1'b0; overflow = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    k_v = '0; k_p = 1'b0; k_rd = 1'b0; k_ec = 1'b0; k_ka = 1'b0; k_oi = 1'b0;
    k_d = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock cycle: apply inputs, compare against the model, then advance model and FIFO
  task automatic step;
    int g;
    logic ci, err;
    logic [1:0] jj;
    @(negedge clk);
    req_valid = k_v; req_data = k_d; pause = k_p; err_clr = k_ec;
    full = (fcnt == DEPTH); almostfull = (fcnt == DEPTH - 1);
    wr_ack = f_ack & ~k_ka; overflow = f_ovf | k_oi;
    #1;
    ci = (m_state == 0) && !k_p && !full && !(almostfull && m_wr);
    g = -1;
    for (int k = 0; k < N; k++) begin
      jj = 2'((m_last + 1 + k) % N);
      if (ci && g < 0 && k_v[jj]) g = int'(jj);
    end
    chk("req_ready", int'(req_ready), g < 0 ? 0 : (1 << g));
    chk("wr_en", int'(wr_en), int'(m_wr));
    chk("data_in", int'(data_in), int'(m_data));
    chk("grant_id", int'(grant_id), m_gid);
    chk("state", int'(state), m_state);
    chk("ack_err", int'(ack_err), int'(m_err));
    chk("accept_cnt", int'(accept_cnt), m_cnt);
    err = (m_pend && !wr_ack) || overflow;
    m_pend = m_wr;
    m_wr = (g >= 0);
    if (g >= 0) begin
      m_data = k_d[g*W +: W];
      m_gid = g;
      m_last = g;
      m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    end
    if (err) begin
      m_state = 2; m_err = 1'b1;
    end else if (m_state == 2) begin
      if (k_ec) begin m_state = 0; m_err = 1'b0; end
    end else m_state = k_p ? 1 : 0;
    f_ovf = wr_en && (fcnt == DEPTH);
    if (f_ovf) f_ovf_seen = 1'b1;
    f_ack = wr_en && (fcnt < DEPTH);
    fcnt = fcnt - ((k_rd && fcnt > 0) ? 1 : 0) + (f_ack ? 1 : 0);
  endtask

  initial begin
    f_ovf_seen = 1'b0;
    tbl[0] = '{4'hF, 4'h1, 1'b0, 0, 0};
    tbl[1] = '{4'hF, 4'h2, 1'b1, 0, 1};
    tbl[2] = '{4'hF, 4'h4, 1'b1, 1, 2};
    tbl[3] = '{4'hF, 4'h8, 1'b1, 2, 3};
    tbl[4] = '{4'h4, 4'h4, 1'b1, 3, 4};
    tbl[5] = '{4'h4, 4'h4, 1'b1, 2, 5};
    tbl[6] = '{4'h4, 4'h4, 1'b1, 2, 6};
    tbl[7] = '{4'h0, 4'h0, 1'b1, 2, 7};
    tbl[8] = '{4'h3, 4'h1, 1'b0, 2, 7};
    tbl[9] = '{4'h3, 4'h2, 1'b1, 0, 8};
    idle_inputs();
    req_valid = 4'hF;
    req_data = '1;
    #12;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_data", int'(data_in), 0);
    chk("rst_gid", int'(grant_id), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    chk("rst_cnt", int'(accept_cnt), 0);

    do_reset();
    k_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      k_v = tbl[i].v;
      step();
      chk($sformatf("tbl%0d_ready", i), int'(req_ready), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_wr_en", i), int'(wr_en), int'(tbl[i].we));
      chk($sformatf("tbl%0d_gid", i), int'(grant_id), tbl[i].gid);
      chk($sformatf("tbl%0d_cnt", i), int'(accept_cnt), tbl[i].cnt);
      if (i > 0) chk($sformatf("tbl%0d_data", i), int'(data_in), 'hA000 + tbl[i].gid);
    end

    do_reset();
    k_v = 4'hF;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 8) chk("afull_8th", int'({wr_en, almostfull, req_ready}), 'b110000);
      pulses += int'(wr_en);
    end
    chk("full_pulses", pulses, 8);
    k_rd = 1'b1;
    step();
    k_rd = 1'b0;
    pulses = int'(wr_en);
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += int'(wr_en);
    end
    chk("read_regrant", pulses, 1);
    chk("no_overflow_full", int'(f_ovf_seen), 0);

    do_reset();
    k_v = 4'hF; k_rd = 1'b1;
    step();
    step();
    k_p = 1'b1;
    step();
    chk("pause_ready", int'(req_ready), 0);
    step();
    chk("paused_state", int'(state), 1);
    k_p = 1'b0;
    step();
    chk("unpause_ready", int'(req_ready), 0);
    step();
    chk("resume_grant2", int'(req_ready), 4);

    do_reset();
    k_v = 4'hF; k_rd = 1'b1;
    step();
    step();
    k_ka = 1'b1;
    step();
    k_ka = 1'b0;
    step();
    chk("err_state", int'(state), 2);
    chk("err_flag", int'(ack_err), 1);
    step();
    chk("err_ready", int'(req_ready), 0);
    k_ec = 1'b1; k_oi = 1'b1;
    step();
    k_oi = 1'b0;
    step();
    chk("err_wins_state", int'(state), 2);
    chk("err_wins_flag", int'(ack_err), 1);
    k_ec = 1'b0;
    step();
    chk("clr_state", int'(state), 0);
    chk("clr_flag", int'(ack_err), 0);
    chk("clr_grants", int'(|req_ready), 1);

    do_reset();
    k_v = 4'hF; k_rd = 1'b1;
    step();
    step();
    k_oi = 1'b1;
    step();
    k_oi = 1'b0;
    step();
    chk("pre_rst_wr_en", int'(wr_en), 1);
    chk("pre_rst_ack_err", int'(ack_err), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_wr_en", int'(wr_en), 0);
    chk("async_cnt", int'(accept_cnt), 0);
    chk("async_ack_err", int'(ack_err), 0);
    chk("async_ready", int'(req_ready), 0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_grant0", int'(req_ready), 1);

    do_reset();
    for (int i = 0; i < 700; i++) begin
      k_v = 4'($urandom);
      k_p = ($urandom % 12 == 0);
      k_rd = (i < 350) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      k_ec = ($urandom % 4 == 0);
      k_ka = ($urandom % 40 == 0);
      k_oi = ($urandom % 100 == 0);
      k_d = {$urandom, $urandom};
      step();
    end
    chk("no_overflow_rand", int'(f_ovf_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
